// File: rtl/dino_pkg.sv
// Shared definitions for the obstacle scheduler: state encoding, default geometry/timing
// and small helpers for speed derivation and sprite-type folding.
package dino_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  localparam int SPAWN_X_DEF    = 160;
  localparam int MIN_GAP_DEF    = 40;
  localparam int NUM_OBS_TYPES  = 5;
  localparam int MAX_SPEED_STEP = 3;

  // Speed grows with the BCD hundreds digit, capped so obstacles stay readable.
  function automatic logic [2:0] speed_from_hundreds(input logic [3:0] hundreds);
    logic [2:0] spd;
    if (hundreds > 4'(MAX_SPEED_STEP)) begin
      spd = 3'(MAX_SPEED_STEP) + 3'd1;
    end else begin
      spd = hundreds[2:0] + 3'd1;
    end
    return spd;
  endfunction

  function automatic logic [2:0] fold_type(input logic [2:0] raw);
    logic [2:0] t;
    if (raw < 3'(NUM_OBS_TYPES)) begin
      t = raw;
    end else begin
      t = raw - 3'(NUM_OBS_TYPES);
    end
    return t;
  endfunction

endpackage

// File: rtl/obstacle_scheduler_if.sv
// Game-side bus of the obstacle scheduler: tick/pulse inputs, randomness and score in,
// per-slot obstacle state and scheduler state out.
interface obstacle_scheduler_if #(parameter int CONV = 2);
  logic           i_tick;
  logic           i_game_start;
  logic           i_game_over;
  logic [7:0]     i_rng;
  logic [15:0]    i_score;
  logic [9:CONV]  o_obs1_pos;
  logic [9:CONV]  o_obs2_pos;
  logic [2:0]     o_obs1_type;
  logic [2:0]     o_obs2_type;
  logic           o_obs1_active;
  logic           o_obs2_active;
  logic [1:0]     o_state;

  modport master (
    output i_tick, i_game_start, i_game_over, i_rng, i_score,
    input  o_obs1_pos, o_obs2_pos, o_obs1_type, o_obs2_type,
           o_obs1_active, o_obs2_active, o_state
  );

  modport slave (
    input  i_tick, i_game_start, i_game_over, i_rng, i_score,
    output o_obs1_pos, o_obs2_pos, o_obs1_type, o_obs2_type,
           o_obs1_active, o_obs2_active, o_state
  );
endinterface

// File: rtl/obs_slot.sv
// One obstacle slot: position/type/active registers, leftward motion and expiry.
// An expired or cleared slot is parked at SPAWN_X so it is never drawn on screen.
module obs_slot
  import dino_pkg::*;
#(
  parameter int CONV    = 2,
  parameter int SPAWN_X = SPAWN_X_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          move_i,
  input  logic [2:0]    speed_i,
  input  logic          spawn_i,
  input  logic [2:0]    spawn_type_i,
  output logic [9:CONV] pos_o,
  output logic [2:0]    type_o,
  output logic          active_o
);

  localparam int PW = 10 - CONV;
  localparam logic [PW-1:0] SPAWN_POS = PW'(SPAWN_X);

  logic [9:CONV] pos_q, pos_d, speed_ext_s;
  logic [2:0]    type_q, type_d;
  logic          active_q, active_d;

  assign speed_ext_s = PW'(speed_i);

  // Next-state: clear beats spawn beats motion; a slot too close to the edge expires instead of wrapping.
  always_comb begin
    pos_d    = pos_q;
    type_d   = type_q;
    active_d = active_q;
    if (clear_i) begin
      pos_d    = SPAWN_POS;
      type_d   = 3'd0;
      active_d = 1'b0;
    end else if (spawn_i) begin
      pos_d    = SPAWN_POS;
      type_d   = spawn_type_i;
      active_d = 1'b1;
    end else if (move_i && active_q) begin
      if (pos_q >= speed_ext_s) begin
        pos_d = pos_q - speed_ext_s;
      end else begin
        pos_d    = SPAWN_POS;
        active_d = 1'b0;
      end
    end else begin
      pos_d = pos_q;
    end
  end

  // Slot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q    <= SPAWN_POS;
      type_q   <= 3'd0;
      active_q <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      type_q   <= type_d;
      active_q <= active_d;
    end
  end

  assign pos_o    = pos_q;
  assign type_o   = type_q;
  assign active_o = active_q;

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle scheduler top: run/over FSM, spawn gap counter, speed from score and
// spawn arbitration across two obs_slot instances.
module obstacle_scheduler
  import dino_pkg::*;
#(
  parameter int CONV    = 2,
  parameter int SPAWN_X = SPAWN_X_DEF,
  parameter int MIN_GAP = MIN_GAP_DEF
) (
  input  logic clk,
  input  logic rst,
  obstacle_scheduler_if.slave bus
);

  localparam logic [7:0] MIN_GAP_V = 8'(MIN_GAP);

  state_e     state_q;
  logic [7:0] gap_cnt_q;
  logic [7:0] gap_thr_q;

  logic       run_s, tick_run_s, start_s;
  logic [2:0] speed_s, type_s;
  logic [7:0] gap_inc_s;
  logic       free1_s, free2_s;
  logic       spawn_ok_s, spawn1_s, spawn2_s;
  logic       unused_s;

  assign unused_s   = ^{bus.i_score[15:12], bus.i_score[7:0]};

  assign run_s      = (state_q == ST_RUN);
  // A game-over pulse in the same cycle swallows the tick.
  assign tick_run_s = run_s && bus.i_tick && !bus.i_game_over;
  assign start_s    = !run_s && bus.i_game_start;
  assign speed_s    = speed_from_hundreds(bus.i_score[11:8]);
  assign type_s     = fold_type(bus.i_rng[7:5]);
  assign gap_inc_s  = (gap_cnt_q == 8'd255) ? 8'd255 : gap_cnt_q + 8'd1;

  // Freedom is judged on pre-tick state, so a slot expiring on this tick cannot respawn on it.
  assign free1_s    = !bus.o_obs1_active;
  assign free2_s    = !bus.o_obs2_active;
  assign spawn_ok_s = tick_run_s && (gap_inc_s >= gap_thr_q) && (free1_s || free2_s);
  assign spawn1_s   = spawn_ok_s && free1_s;
  assign spawn2_s   = spawn_ok_s && !free1_s && free2_s;

  // Scheduler FSM with the gap counter and spawn threshold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gap_cnt_q <= 8'd0;
      gap_thr_q <= MIN_GAP_V;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.i_game_over) begin
            state_q <= ST_OVER;
          end else if (bus.i_tick) begin
            if (spawn_ok_s) begin
              gap_cnt_q <= 8'd0;
              gap_thr_q <= MIN_GAP_V + {3'd0, bus.i_rng[4:0]};
            end else begin
              gap_cnt_q <= gap_inc_s;
            end
          end else begin
            state_q <= ST_RUN;
          end
        end
        default: begin
          if (bus.i_game_start) begin
            state_q   <= ST_RUN;
            gap_cnt_q <= 8'd0;
            gap_thr_q <= MIN_GAP_V;
          end else if (state_q == ST_OVER) begin
            state_q <= ST_OVER;
          end else begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.o_state = state_q;

  obs_slot #(.CONV(CONV), .SPAWN_X(SPAWN_X)) u_slot1 (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (start_s),
    .move_i       (tick_run_s),
    .speed_i      (speed_s),
    .spawn_i      (spawn1_s),
    .spawn_type_i (type_s),
    .pos_o        (bus.o_obs1_pos),
    .type_o       (bus.o_obs1_type),
    .active_o     (bus.o_obs1_active)
  );

  obs_slot #(.CONV(CONV), .SPAWN_X(SPAWN_X)) u_slot2 (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (start_s),
    .move_i       (tick_run_s),
    .speed_i      (speed_s),
    .spawn_i      (spawn2_s),
    .spawn_type_i (type_s),
    .pos_o        (bus.o_obs2_pos),
    .type_o       (bus.o_obs2_type),
    .active_o     (bus.o_obs2_active)
  );

endmodule
